packet_tx_source: RTL and testbench

- Software-driven AXIS packet transmitter that feeds one ingress port of the packet switch.
- Host writes payload words through an Avalon-MM register interface into a local single-packet buffer, then launches the packet with a destination index.
- The block streams the buffered words as one AXIS packet: tdest on every beat, tlast on the final beat, full tready back-pressure support.
- Used for bring-up, loopback tests and host-originated traffic injection.

---
 rtl/packet_filter_pkg.sv | 20 ++
 rtl/pkt_tx_buffer.sv | 26 ++
 rtl/packet_tx_source.sv | 179 +++++++++++++++++
 tb/tb_packet_tx_source.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_filter_pkg.sv
// Register map, STATUS bit positions and FSM state type shared by the
// host-driven packet transmitter (packet_tx_source) and its buffer.
package packet_filter_pkg;

  localparam logic [7:0] PKT_TX_ADDR_DATA   = 8'h00;
  localparam logic [7:0] PKT_TX_ADDR_LAUNCH = 8'h01;
  localparam logic [7:0] PKT_TX_ADDR_STATUS = 8'h02;

  localparam int unsigned PKT_TX_STAT_BUSY         = 0;
  localparam int unsigned PKT_TX_STAT_OVERFLOW     = 1;
  localparam int unsigned PKT_TX_STAT_EMPTY_LAUNCH = 2;
  localparam int unsigned PKT_TX_STAT_DONE         = 3;
  localparam int unsigned PKT_TX_STAT_COUNT_LSB    = 16;

  typedef enum logic {
    IDLE,
    SEND
  } pkt_tx_state_t;

endpackage

// File: rtl/pkt_tx_buffer.sv
// Single-packet payload store: synchronous write port, asynchronous indexed
// read port so the current beat is visible in the same cycle as rd_ptr.
module pkt_tx_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_tx_source.sv
// Software-driven AXIS packet source: host fills a buffer over Avalon-MM, then
// launches it as one packet. Optional macro PKT_TX_IRQ_EN drives irq from done.
module packet_tx_source
  import packet_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           writedata,
  input  logic                  write,
  input  logic                  chipselect,
  input  logic [7:0]            address,
  input  logic                  read,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  output logic [IDX_WIDTH-1:0]  tx_tdest,
  input  logic                  tx_tready,
  output logic                  irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  pkt_tx_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [IDX_WIDTH-1:0] dest_q, dest_d;
  logic                 overflow_q, overflow_d;
  logic                 empty_launch_q, empty_launch_d;
  logic                 done_q, done_d;
  logic [31:0]          readdata_q, readdata_d;

  logic                  wr_data, wr_launch, wr_status, rd_en;
  logic                  sending, beat_ok, last_beat;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [31:0]           status_word;
  logic [CNT_WIDTH-1:0]  last_idx;
  logic                  unused_wdata;

  assign wr_data   = chipselect && write && (address == PKT_TX_ADDR_DATA);
  assign wr_launch = chipselect && write && (address == PKT_TX_ADDR_LAUNCH);
  assign wr_status = chipselect && write && (address == PKT_TX_ADDR_STATUS);
  assign rd_en     = chipselect && read;

  assign sending   = (state_q == SEND);
  assign beat_ok   = sending && tx_tready;
  assign last_idx  = count_q - CNT_WIDTH'(1);
  assign last_beat = (rd_ptr_q == last_idx);

  assign unused_wdata = ^writedata[31:DATA_WIDTH];

  pkt_tx_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) u_buffer (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_ptr_q),
    .wdata(writedata[DATA_WIDTH-1:0]),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(rd_word)
  );

  always_comb begin
    status_word                           = '0;
    status_word[PKT_TX_STAT_BUSY]         = sending;
    status_word[PKT_TX_STAT_OVERFLOW]     = overflow_q;
    status_word[PKT_TX_STAT_EMPTY_LAUNCH] = empty_launch_q;
    status_word[PKT_TX_STAT_DONE]         = done_q;
    status_word[PKT_TX_STAT_COUNT_LSB +: CNT_WIDTH] = count_q;
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    dest_d         = dest_q;
    overflow_d     = overflow_q;
    empty_launch_d = empty_launch_q;
    done_d         = done_q;
    buf_we         = 1'b0;

    // Clears come first so any flag set later in this block wins.
    if (wr_status) begin
      if (writedata[PKT_TX_STAT_OVERFLOW])     overflow_d     = 1'b0;
      if (writedata[PKT_TX_STAT_EMPTY_LAUNCH]) empty_launch_d = 1'b0;
      if (writedata[PKT_TX_STAT_DONE])         done_d         = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_data) begin
          if (count_q < CNT_WIDTH'(DEPTH)) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CNT_WIDTH'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else if (wr_launch) begin
          if (count_q != '0) begin
            dest_d   = writedata[IDX_WIDTH-1:0];
            rd_ptr_d = '0;
            state_d  = SEND;
          end else begin
            empty_launch_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (wr_data || wr_launch) begin
          overflow_d = 1'b1;
        end
        if (beat_ok) begin
          rd_ptr_d = rd_ptr_q + CNT_WIDTH'(1);
          if (last_beat) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            done_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = (address == PKT_TX_ADDR_STATUS) ? status_word : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      dest_q         <= '0;
      overflow_q     <= 1'b0;
      empty_launch_q <= 1'b0;
      done_q         <= 1'b0;
      readdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      dest_q         <= dest_d;
      overflow_q     <= overflow_d;
      empty_launch_q <= empty_launch_d;
      done_q         <= done_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign tx_tvalid = sending;
  assign tx_tdata  = sending ? rd_word : '0;
  assign tx_tlast  = sending && last_beat;
  assign tx_tdest  = dest_q;

`ifdef PKT_TX_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_packet_tx_source.sv
// Directed self-checking bench for packet_tx_source with hand-computed expectations.
module tb_packet_tx_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata;
  logic        write, chipselect, read;
  logic [7:0]  address;
  logic [31:0] readdata;
  logic [15:0] tx_tdata;
  logic        tx_tvalid, tx_tlast;
  logic [1:0]  tx_tdest;
  logic        tx_tready;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] beat_data[$];
  logic        beat_last[$];
  logic [1:0]  beat_dest[$];
  int          cycles_used;
  int          stall_samples;
  int          stall_diff;

`ifdef PKT_TX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  packet_tx_source dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .write     (write),
    .chipselect(chipselect),
    .address   (address),
    .read      (read),
    .readdata  (readdata),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tlast  (tx_tlast),
    .tx_tdest  (tx_tdest),
    .tx_tready (tx_tready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1ms");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
    chipselect = 1'b1; write = 1'b1; address = addr; writedata = data;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
  endtask

  task automatic reg_read(input logic [7:0] addr, output logic [31:0] data);
    chipselect = 1'b1; read = 1'b1; address = addr;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; address = '0;
    data = readdata;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives tready (optionally low for stall_len cycles when beat stall_at is
  // offered) and records accepted beats until tlast or the cycle budget.
  task automatic capture(input string tag, input int max_cycles, input int stall_at,
                         input int stall_len);
    int   cyc;
    int   stalled;
    bit   got_last;
    logic [18:0] snap;
    cyc = 0; stalled = 0; got_last = 0; snap = '0;
    beat_data.delete(); beat_last.delete(); beat_dest.delete();
    stall_samples = 0; stall_diff = 0;
    while (!got_last && cyc < max_cycles) begin
      tx_tready = !((beat_data.size() == stall_at) && (stalled < stall_len));
      #4;
      if (tx_tvalid && tx_tready) begin
        beat_data.push_back(tx_tdata);
        beat_last.push_back(tx_tlast);
        beat_dest.push_back(tx_tdest);
        if (tx_tlast) got_last = 1;
      end else if (tx_tvalid) begin
        if (stalled == 0) snap = {tx_tlast, tx_tdest, tx_tdata};
        else if (snap !== {tx_tlast, tx_tdest, tx_tdata}) stall_diff++;
        stalled++;
        stall_samples++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cycles_used = cyc;
    tx_tready = 1'b1;
    if (!got_last) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  int          bad;

  initial begin
    reset = 1'b1; writedata = '0; write = 1'b0; chipselect = 1'b0;
    address = '0; read = 1'b0; tx_tready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, tx_tlast},  32'd0);
    check("rst_tdest",  {30'd0, tx_tdest},  32'd0);
    check("rst_tdata",  {16'd0, tx_tdata},  32'd0);
    check("rst_irq",    {31'd0, irq},       32'd0);
    check("rst_rdata",  readdata,           32'd0);
    reset = 1'b0;

    // 3-word packet, full-rate.
    reg_write(8'h0, 32'hFFFF_00A1);
    reg_write(8'h0, 32'h0000_00B2);
    reg_write(8'h0, 32'h0000_00C3);
    reg_read(8'h2, rd);
    check("t1_pre_status", rd, 32'h0003_0000);
    reg_write(8'h1, 32'd2);
    capture("t1", 20, -1, 0);
    check("t1_nbeats", beat_data.size(), 3);
    check("t1_cycles", cycles_used, 3);
    if (beat_data.size() == 3) begin
      check("t1_d0", beat_data[0], 16'h00A1);
      check("t1_d1", beat_data[1], 16'h00B2);
      check("t1_d2", beat_data[2], 16'h00C3);
      check("t1_last", {beat_last[0], beat_last[1], beat_last[2]}, 3'b001);
      check("t1_dest", {beat_dest[0], beat_dest[1], beat_dest[2]}, 6'b10_10_10);
    end
    check("t1_tvalid_after", {31'd0, tx_tvalid}, 32'd0);
    check("t1_irq", {31'd0, irq}, {31'd0, IRQ_ON});
    reg_read(8'h2, rd);
    check("t1_status", rd, 32'h0000_0008);
    reg_read(8'h5, rd);
    check("t1_unmapped", rd, 32'h0);
    reg_write(8'h2, 32'h8);
    check("t1_irq_clr", {31'd0, irq}, 32'd0);
    reg_read(8'h2, rd);
    check("t1_status_clr", rd, 32'h0);

    // Same packet, beat 2 stalled 4 cycles.
    reg_write(8'h0, 32'hA1);
    reg_write(8'h0, 32'hB2);
    reg_write(8'h0, 32'hC3);
    reg_write(8'h1, 32'd2);
    capture("t2", 30, 1, 4);
    check("t2_nbeats", beat_data.size(), 3);
    check("t2_cycles", cycles_used, 7);
    check("t2_stall_n", stall_samples, 4);
    check("t2_stall_hold", stall_diff, 0);
    if (beat_data.size() == 3) begin
      check("t2_d1", beat_data[1], 16'h00B2);
      check("t2_last", {beat_last[0], beat_last[1], beat_last[2]}, 3'b001);
    end
    reg_write(8'h2, 32'hE);

    // DEPTH+1 words: the 65th is dropped.
    for (int i = 0; i < 65; i++) reg_write(8'h0, 32'h1000 + i);
    reg_read(8'h2, rd);
    check("t3_pre_status", rd, 32'h0040_0002);
    reg_write(8'h1, 32'd1);
    capture("t3", 200, -1, 0);
    check("t3_nbeats", beat_data.size(), 64);
    check("t3_cycles", cycles_used, 64);
    bad = 0;
    foreach (beat_data[i]) begin
      if (beat_data[i] !== 16'(32'h1000 + i)) bad++;
      if (beat_last[i] !== (i == 63)) bad++;
      if (beat_dest[i] !== 2'd1) bad++;
    end
    check("t3_beat_errs", bad, 0);
    reg_read(8'h2, rd);
    check("t3_status", rd, 32'h0000_000A);
    reg_write(8'h2, 32'hA);

    // Writes during SEND are dropped and flag overflow.
    tx_tready = 1'b0;
    reg_write(8'h0, 32'h11);
    reg_write(8'h0, 32'h22);
    reg_write(8'h1, 32'd3);
    reg_write(8'h0, 32'h77);
    capture("t3b", 20, -1, 0);
    check("t3b_nbeats", beat_data.size(), 2);
    if (beat_data.size() == 2) begin
      check("t3b_d", {beat_data[0], beat_data[1]}, 32'h0011_0022);
      check("t3b_dest", {beat_dest[0], beat_dest[1]}, 4'b11_11);
    end
    reg_read(8'h2, rd);
    check("t3b_status", rd, 32'h0000_000A);
    reg_write(8'h2, 32'hA);

    // Empty launch.
    reg_write(8'h1, 32'd2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (tx_tvalid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("t4_no_valid", bad, 0);
    reg_read(8'h2, rd);
    check("t4_status", rd, 32'h0000_0004);
    reg_write(8'h2, 32'h4);
    reg_read(8'h2, rd);
    check("t4_status_clr", rd, 32'h0);

    // Reset in the middle of a 5-word packet.
    for (int i = 0; i < 5; i++) reg_write(8'h0, 32'h50 + i);
    reg_write(8'h1, 32'd3);
    check("t5_beat1_valid", {31'd0, tx_tvalid}, 32'd1);
    @(posedge clk); #1;
    check("t5_beat2_data", {16'd0, tx_tdata}, 32'h51);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_valid", {31'd0, tx_tvalid}, 32'd0);
    check("t5_rst_dest", {30'd0, tx_tdest}, 32'd0);
    reset = 1'b0;
    reg_read(8'h2, rd);
    check("t5_status", rd, 32'h0);
    reg_write(8'h0, 32'hDEAD);
    reg_write(8'h0, 32'hBEEF);
    reg_write(8'h1, 32'd0);
    capture("t5", 20, -1, 0);
    check("t5_nbeats", beat_data.size(), 2);
    if (beat_data.size() == 2) begin
      check("t5_d", {beat_data[0], beat_data[1]}, 32'hDEAD_BEEF);
      check("t5_last", {beat_last[0], beat_last[1]}, 2'b01);
      check("t5_dest", {beat_dest[0], beat_dest[1]}, 4'b00_00);
    end
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
